// File: rtl/sum_acc_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and
// default parameter values used by the accumulator and its saturating adder.
package sum_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_ACC_W = 16;
   localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/sat_add.sv
// Saturating adder: adds an unsigned IN_W-bit value to an ACC_W-bit
// accumulator, clamping to the all-ones maximum and flagging the clamp.
module sat_add #(
   parameter int ACC_W = 16,
   parameter int IN_W  = 9
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [IN_W-1:0]  val_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             ovf_o
);

   logic [ACC_W:0] wideSum;

   // Compute the sum one bit wider than the accumulator; the top bit is
   // the overflow indicator and forces the result to the maximum value.
   always_comb begin
      wideSum = {1'b0, acc_i} + {{(ACC_W - IN_W + 1){1'b0}}, val_i};
      ovf_o   = wideSum[ACC_W];
      sum_o   = wideSum[ACC_W] ? {ACC_W{1'b1}} : wideSum[ACC_W-1:0];
   end

endmodule

// File: rtl/sum_accumulator.sv
// Burst accumulator for adder results. A start pulse in IDLE launches a
// burst of len samples, each {carry_in, sum_in}, summed with saturation.
// The result is then held on a valid/ready output handshake.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;
   logic             inReady_q, outValid_q, busy_q;

   logic [WIDTH:0]   sampleVal;
   logic [ACC_W-1:0] addSum;
   logic             addOvf;
   logic [CNT_W-1:0] cntInc;
   logic             sampleAccept;

   assign sampleVal    = {carry_in, sum_in};
   assign cntInc       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   assign sampleAccept = in_valid & inReady_q;

   sat_add #(
      .ACC_W (ACC_W),
      .IN_W  (WIDTH + 1)
   ) u_satAdd (
      .acc_i (acc_q),
      .val_i (sampleVal),
      .sum_o (addSum),
      .ovf_o (addOvf)
   );

   // Next-state logic: start a burst from IDLE, accumulate accepted samples
   // until the latched length is reached, then wait for the output handshake.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               len_d   = len;
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (sampleAccept) begin
               acc_d = addSum;
               ovf_d = ovf_q | addOvf;
               cnt_d = cntInc;
               if (cntInc == len_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; handshake outputs are registered decodes
   // of the next state so they never depend combinationally on inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         inReady_q  <= 1'b0;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         ovf_q      <= ovf_d;
         inReady_q  <= (state_d == ACCUM);
         outValid_q <= (state_d == DONE);
         busy_q     <= (state_d != IDLE);
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign busy      = busy_q;
   assign out_total = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed testbench for sum_accumulator. A 16-bit accumulator instance
// covers the normal bursts; a 10-bit instance covers saturation.
module tb_sum_accumulator;

   logic        clk;
   logic        rst;
   logic        start;
   logic        startSat;
   logic [3:0]  len;
   logic        inValid;
   logic [7:0]  sumIn;
   logic        carryIn;
   logic        outReady;

   logic        inReady, outValid, outOvf, busy;
   logic [15:0] outTotal;
   logic [3:0]  outCount;

   logic        inReadyS, outValidS, outOvfS, busyS;
   logic [9:0]  outTotalS;
   logic [3:0]  outCountS;

   int checkCount;
   int passCount;

   sum_accumulator #(.WIDTH(8), .ACC_W(16), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .sum_in    (sumIn),
      .carry_in  (carryIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_total (outTotal),
      .out_count (outCount),
      .out_ovf   (outOvf),
      .busy      (busy)
   );

   sum_accumulator #(.WIDTH(8), .ACC_W(10), .CNT_W(4)) dutSat (
      .clk       (clk),
      .rst       (rst),
      .start     (startSat),
      .len       (len),
      .in_valid  (inValid),
      .in_ready  (inReadyS),
      .sum_in    (sumIn),
      .carry_in  (carryIn),
      .out_valid (outValidS),
      .out_ready (outReady),
      .out_total (outTotalS),
      .out_count (outCountS),
      .out_ovf   (outOvfS),
      .busy      (busyS)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then settle just after the next rising edge.
   task automatic applyStimulus(input logic s16, input logic s10, input logic [3:0] lenV,
                                input logic validV, input logic carryV, input logic [7:0] sumV,
                                input logic readyV);
      start    = s16;
      startSat = s10;
      len      = lenV;
      inValid  = validV;
      carryIn  = carryV;
      sumIn    = sumV;
      outReady = readyV;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Directed sequence of bursts with hand-computed expected results.
   initial begin
      checkCount = 0;
      passCount  = 0;
      rst      = 1'b1;
      start    = 1'b0;
      startSat = 1'b0;
      len      = 4'd0;
      inValid  = 1'b0;
      sumIn    = 8'd0;
      carryIn  = 1'b0;
      outReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready",  32'(inReady),  32'd0);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_total",     32'(outTotal), 32'd0);
      checkOutput("rst_count",     32'(outCount), 32'd0);
      checkOutput("rst_ovf",       32'(outOvf),   32'd0);
      checkOutput("rst_busy",      32'(busy),     32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);

      // Reset in the middle of a four-sample burst.
      applyStimulus(1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("start_in_ready", 32'(inReady), 32'd1);
      checkOutput("start_busy",     32'(busy),    32'd1);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h03, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h04, 1'b0);
      checkOutput("partial_total", 32'(outTotal), 32'd7);
      checkOutput("partial_count", 32'(outCount), 32'd2);
      inValid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("midrst_total",     32'(outTotal), 32'd0);
      checkOutput("midrst_count",     32'(outCount), 32'd0);
      checkOutput("midrst_in_ready",  32'(inReady),  32'd0);
      checkOutput("midrst_busy",      32'(busy),     32'd0);
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h05, 1'b0);
      checkOutput("len1_valid", 32'(outValid), 32'd1);
      checkOutput("len1_total", 32'(outTotal), 32'd5);
      checkOutput("len1_count", 32'(outCount), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("len1_release", 32'(outValid), 32'd0);

      // Basic three-sample burst at full rate.
      applyStimulus(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h10, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h20, 1'b0);
      checkOutput("basic_not_done", 32'(outValid), 32'd0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h30, 1'b0);
      checkOutput("basic_valid",    32'(outValid), 32'd1);
      checkOutput("basic_total",    32'(outTotal), 32'h0060);
      checkOutput("basic_count",    32'(outCount), 32'd3);
      checkOutput("basic_ovf",      32'(outOvf),   32'd0);
      checkOutput("basic_in_ready", 32'(inReady),  32'd0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Carry bit contributes 256 per sample: 511 + 257 = 768.
      applyStimulus(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'h01, 1'b0);
      checkOutput("carry_valid", 32'(outValid), 32'd1);
      checkOutput("carry_total", 32'(outTotal), 32'd768);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Saturation on the 10-bit instance: 511, 1022, then clamp at 1023.
      applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
      checkOutput("sat_pre_total", 32'(outTotalS), 32'd1022);
      checkOutput("sat_pre_ovf",   32'(outOvfS),   32'd0);
      checkOutput("idle_unused",   32'(busy),      32'd0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
      checkOutput("sat_hit_total", 32'(outTotalS), 32'h3FF);
      checkOutput("sat_hit_ovf",   32'(outOvfS),   32'd1);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
      checkOutput("sat_valid", 32'(outValidS), 32'd1);
      checkOutput("sat_total", 32'(outTotalS), 32'h3FF);
      checkOutput("sat_ovf",   32'(outOvfS),   32'd1);
      checkOutput("sat_count", 32'(outCountS), 32'd5);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("sat_release", 32'(outValidS), 32'd0);

      // Gaps, ignored start in ACCUM, and output backpressure.
      applyStimulus(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h07, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 8'hAA, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 8'hAA, 1'b0);
      checkOutput("gap_total",   32'(outTotal), 32'd7);
      checkOutput("gap_count",   32'(outCount), 32'd1);
      checkOutput("gap_waiting", 32'(outValid), 32'd0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h08, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_valid", 32'(outValid), 32'd1);
         checkOutput("hold_total", 32'(outTotal), 32'd15);
         checkOutput("hold_count", 32'(outCount), 32'd2);
         applyStimulus((i == 2) ? 1'b1 : 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 8'h11, 1'b0);
      end
      checkOutput("hold_end_total", 32'(outTotal), 32'd15);
      applyStimulus(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("release_valid",    32'(outValid), 32'd0);
      checkOutput("release_busy",     32'(busy),     32'd0);
      checkOutput("release_in_ready", 32'(inReady),  32'd0);

      // Zero-length burst goes straight to DONE with an empty result.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'h55, 1'b0);
      checkOutput("len0_valid",    32'(outValid), 32'd1);
      checkOutput("len0_total",    32'(outTotal), 32'd0);
      checkOutput("len0_count",    32'(outCount), 32'd0);
      checkOutput("len0_in_ready", 32'(inReady),  32'd0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h55, 1'b1);
      checkOutput("len0_release",  32'(outValid), 32'd0);
      checkOutput("len0_idle_rdy", 32'(inReady),  32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
